filter_ctrl_ramp: RTL

//  Next-generation two-pump filter sequencer. Drives pump A (fill) and pump B (drain) PWM duty

---
 rtl/filter_ctrl_ramp_if.sv | 20 ++
 rtl/filter_ctrl_ramp.sv | 131 +++++++++++++
 2 files changed

// File: rtl/filter_ctrl_ramp_if.sv
// Status/level inputs and slew-limited pump duty outputs of the two-pump filter sequencer.
// The controller takes the slave side; the sensing logic (or a bench) takes the master side.
interface filter_ctrl_ramp_if #(
    parameter int STATUS_W = 4,
    parameter int PWM_W    = 8
);
    logic [STATUS_W-1:0] status_data;
    logic                level_a_full;
    logic                level_b_empty;
    logic                fault_clr;
    logic [PWM_W-1:0]    pwm_duty_a;
    logic [PWM_W-1:0]    pwm_duty_b;
    logic [2:0]          state_o;
    logic                fault;

    modport master (output status_data, level_a_full, level_b_empty, fault_clr,
                    input  pwm_duty_a, pwm_duty_b, state_o, fault);
    modport slave  (input  status_data, level_a_full, level_b_empty, fault_clr,
                    output pwm_duty_a, pwm_duty_b, state_o, fault);
endinterface

// File: rtl/filter_ctrl_ramp.sv
// Two-pump filter sequencer: fill/drain state machine with fill timeout fault and
// soft-start slew limiting on both pump duties (instant ramp-down, stepped ramp-up).
module filter_ctrl_ramp #(
    parameter int STATUS_W       = 4,
    parameter int PWM_W          = 8,
    parameter int PWM_MAX        = 230,
    parameter int PWM_MIN        = 77,
    parameter int PUMP_B_CYCLES  = 250_000_000,
    parameter int FILL_TO_CYCLES = 500_000_000,
    parameter int RAMP_DIV       = 50_000,
    parameter int RAMP_STEP      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    filter_ctrl_ramp_if.slave  bus
);
    localparam logic [2:0] ST_STOP      = 3'd0;
    localparam logic [2:0] ST_FILLING   = 3'd1;
    localparam logic [2:0] ST_DRAIN_MIN = 3'd2;
    localparam logic [2:0] ST_DRAIN_MAX = 3'd3;
    localparam logic [2:0] ST_STOPPING  = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;

    // +1 so the timers can represent their terminal value without wrapping
    localparam int FILL_W  = $clog2(FILL_TO_CYCLES + 1);
    localparam int DWELL_W = $clog2(PUMP_B_CYCLES + 1);
    localparam int DIV_W   = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

    logic [STATUS_W-1:0] status;
    logic [2:0]          state_reg, state_next;
    logic [FILL_W-1:0]   fill_timer_reg;
    logic [DWELL_W-1:0]  dwell_timer_reg;
    logic [DIV_W-1:0]    presc_reg;
    logic                fault_reg;
    logic                crit, fill_timeout, dwell_expired, ramp_tick;
    logic [PWM_W-1:0]    target [2];
    logic [PWM_W-1:0]    duty_q [2];

    assign status        = bus.status_data;
    assign crit          = |status;
    assign fill_timeout  = (fill_timer_reg == FILL_W'(FILL_TO_CYCLES - 1));
    assign dwell_expired = (dwell_timer_reg >= DWELL_W'(PUMP_B_CYCLES));
    assign ramp_tick     = (presc_reg == DIV_W'(RAMP_DIV - 1));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_STOP:      if (crit) state_next = ST_FILLING;
            ST_FILLING: begin
                // timeout outranks the level switch so a stuck-full tank still faults
                if (!crit)                   state_next = ST_STOPPING;
                else if (fill_timeout)       state_next = ST_FAULT;
                else if (!bus.level_a_full)  state_next = ST_DRAIN_MIN;
            end
            ST_DRAIN_MIN: begin
                if (!crit)                   state_next = ST_STOPPING;
                else if (bus.level_b_empty)  state_next = ST_FILLING;
                else if (dwell_expired)      state_next = ST_DRAIN_MAX;
            end
            ST_DRAIN_MAX: begin
                if (!crit)                   state_next = ST_STOPPING;
                else if (bus.level_b_empty)  state_next = ST_FILLING;
            end
            ST_STOPPING:  if (bus.level_b_empty) state_next = ST_STOP;
            ST_FAULT:     if (bus.fault_clr)     state_next = ST_STOP;
            default:      state_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_STOP;
            fault_reg       <= 1'b0;
            presc_reg       <= '0;
            fill_timer_reg  <= '0;
            dwell_timer_reg <= '0;
        end else begin
            state_reg      <= state_next;
            fault_reg      <= (state_next == ST_FAULT);
            presc_reg      <= ramp_tick ? '0 : presc_reg + 1'b1;
            fill_timer_reg <= (state_reg == ST_FILLING) ? fill_timer_reg + 1'b1 : '0;
            if (state_reg != ST_DRAIN_MIN)
                dwell_timer_reg <= '0;
            else if (!dwell_expired)
                dwell_timer_reg <= dwell_timer_reg + 1'b1;
        end
    end

    // index 0 = pump A (fill), index 1 = pump B (drain)
    always_comb begin
        target[0] = '0;
        target[1] = '0;
        case (state_reg)
            ST_FILLING: begin
                target[0] = PWM_W'(PWM_MAX);
                target[1] = bus.level_b_empty ? '0 : PWM_W'(PWM_MAX);
            end
            ST_DRAIN_MIN: target[1] = PWM_W'(PWM_MIN);
            ST_DRAIN_MAX: target[1] = PWM_W'(PWM_MAX);
            ST_STOPPING:  target[1] = bus.level_b_empty ? '0 : PWM_W'(PWM_MAX);
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slew
            logic [PWM_W-1:0] duty_reg;
            logic             step_hits_target;

            // compare in 32 bits so a large step cannot wrap past the duty range
            assign step_hits_target = (32'(duty_reg) + 32'(RAMP_STEP)) >= 32'(target[gi]);

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    duty_reg <= '0;
                else if (target[gi] < duty_reg)
                    duty_reg <= target[gi];
                else if ((target[gi] > duty_reg) && ramp_tick)
                    duty_reg <= step_hits_target ? target[gi] : duty_reg + PWM_W'(RAMP_STEP);
            end

            assign duty_q[gi] = duty_reg;
        end
    endgenerate

    assign bus.pwm_duty_a = duty_q[0];
    assign bus.pwm_duty_b = duty_q[1];
    assign bus.state_o    = state_reg;
    assign bus.fault      = fault_reg;
endmodule
